comparator_4bit: RTL and testbench



---
 rtl/comparator_pkg.sv | 14 +
 rtl/comparator_core.sv | 33 +++
 rtl/comparator_4bit.sv | 54 +++++
 tb/tb_comparator_4bit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared constants for the registered magnitude comparator.
// Result flags are always packed in {eq, lt, gt} order.
package comparator_pkg;

   localparam int DEFAULT_WIDTH = 4;

   typedef logic [2:0] cmp_flags_t;

   localparam cmp_flags_t CMP_NONE = 3'b000;
   localparam cmp_flags_t CMP_EQ   = 3'b100;
   localparam cmp_flags_t CMP_LT   = 3'b010;
   localparam cmp_flags_t CMP_GT   = 3'b001;

endpackage

// File: rtl/comparator_core.sv
// Combinational unsigned compare, MSB-first: the highest differing bit decides lt/gt.
// Output is one-hot {eq, lt, gt}.
module comparator_core
   import comparator_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output cmp_flags_t       flags
);

   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] lt_bit;
   logic [WIDTH-1:0] gt_bit;

   assign diff = a ^ b;

   // Each bit only wins if every bit above it matches, so at most one bit fires.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         localparam logic [WIDTH-1:0] ABOVE_MASK = {WIDTH{1'b1}} << (gi + 1);
         logic no_diff_above;
         assign no_diff_above = ~|(diff & ABOVE_MASK);
         assign lt_bit[gi]    = no_diff_above & diff[gi] & b[gi];
         assign gt_bit[gi]    = no_diff_above & diff[gi] & a[gi];
      end
   endgenerate

   assign flags = {~|diff, |lt_bit, |gt_bit};

endmodule

// File: rtl/comparator_4bit.sv
// Registered magnitude comparator: flags captured one cycle after a valid operand pair,
// held while idle; out_valid marks the cycle a fresh result is presented.
module comparator_4bit
   import comparator_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic             eq,
   output logic             lt,
   output logic             gt
);

   cmp_flags_t core_flags;
   cmp_flags_t flags_d;
   cmp_flags_t flags_q;
   logic       valid_d;
   logic       valid_q;

   comparator_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .a     (a),
      .b     (b),
      .flags (core_flags)
   );

   always_comb begin
      flags_d = flags_q;
      valid_d = in_valid;
      if (in_valid) begin
         flags_d = core_flags;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= CMP_NONE;
         valid_q <= 1'b0;
      end else begin
         flags_q <= flags_d;
         valid_q <= valid_d;
      end
   end

   assign out_valid    = valid_q;
   assign {eq, lt, gt} = flags_q;

endmodule

// File: tb/tb_comparator_4bit.sv
// Scoreboard bench for comparator_4bit: expected flags queued at drive time,
// popped and compared when the registered result appears.
module tb_comparator_4bit;
   import comparator_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       out_valid;
   logic       eq;
   logic       lt;
   logic       gt;

   int         total_cnt;
   int         bad_cnt;
   cmp_flags_t exp_q[$];
   cmp_flags_t held;

   comparator_4bit #(
      .WIDTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .eq        (eq),
      .lt        (lt),
      .gt        (gt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total_cnt++;
      if (actual !== expected) begin
         bad_cnt++;
         $display("FAIL %s: got=%0h want=%0h t=%0t", tag, actual, expected, $time);
      end
   endtask

   function automatic cmp_flags_t ref_cmp(input logic [3:0] x, input logic [3:0] y);
      int ux;
      int uy;
      ux = int'(x);
      uy = int'(y);
      if (ux == uy) return CMP_EQ;
      else if (ux < uy) return CMP_LT;
      else return CMP_GT;
   endfunction

   // Drive one cycle of stimulus, then check the registered outputs 1 time unit after the edge.
   task automatic step(input logic v, input logic [3:0] av, input logic [3:0] bv);
      cmp_flags_t exp;
      in_valid = v;
      a        = av;
      b        = bv;
      if (v) exp_q.push_back(ref_cmp(av, bv));
      @(posedge clk);
      #1;
      if (v) begin
         exp  = exp_q.pop_front();
         held = exp;
         check("out_valid_set", 32'(out_valid), 32'd1);
         check("flags", 32'({eq, lt, gt}), 32'(exp));
      end else begin
         check("out_valid_clr", 32'(out_valid), 32'd0);
         check("flags_hold", 32'({eq, lt, gt}), 32'(held));
      end
      if (out_valid) check("onehot", 32'($countones({eq, lt, gt})), 32'd1);
      $display("txn v=%b a=%b b=%b -> out_valid=%b eq=%b lt=%b gt=%b", v, av, bv, out_valid, eq, lt, gt);
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      held      = CMP_NONE;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;

      #12;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_flags", 32'({eq, lt, gt}), 32'(CMP_NONE));
      @(negedge clk);
      rst_n = 1'b1;

      // A result in flight, then reset asserted between edges.
      step(1'b1, 4'b0001, 4'b0000);
      in_valid = 1'b1;
      a        = 4'b0011;
      b        = 4'b0011;
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      held = CMP_NONE;
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_flags", 32'({eq, lt, gt}), 32'(CMP_NONE));
      @(posedge clk);
      #1;
      check("rst_held_out_valid", 32'(out_valid), 32'd0);
      check("rst_held_flags", 32'({eq, lt, gt}), 32'(CMP_NONE));
      @(negedge clk);
      rst_n = 1'b1;

      step(1'b1, 4'b1100, 4'b1100);
      step(1'b1, 4'b0100, 4'b1100);
      step(1'b1, 4'b1111, 4'b1100);
      step(1'b1, 4'b0000, 4'b0000);
      step(1'b0, 4'b1111, 4'b0000);
      step(1'b0, 4'b0000, 4'b1111);

      // Back-to-back pipeline and boundary pairs.
      step(1'b1, 4'b0001, 4'b0000);
      step(1'b1, 4'b0000, 4'b0001);
      step(1'b1, 4'b1010, 4'b1010);
      step(1'b1, 4'b1111, 4'b0000);
      step(1'b1, 4'b1000, 4'b0000);
      step(1'b1, 4'b0111, 4'b1111);
      step(1'b0, 4'b0000, 4'b0000);

      for (int i = 0; i < 256; i++) begin
         step(1'b1, 4'(i >> 4), 4'(i));
      end
      step(1'b0, 4'b0101, 4'b1010);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule
